// File: rtl/hazard_sb_pkg.sv
// rtl/hazard_sb_pkg.sv - shared hazard/forwarding encodings for the pipeline
// Contents: forward-select codes, MDU sequencer state encoding, counter width helper.
package hazard_sb_pkg;

   // Operand source select for the Execute-stage ALU inputs
   localparam logic [1:0] FWD_RF  = 2'b00;   // register file value
   localparam logic [1:0] FWD_WB  = 2'b01;   // Writeback result
   localparam logic [1:0] FWD_MEM = 2'b10;   // Memory-stage result

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_e;

   // ceil(log2(lat)), never below one bit so the counter always exists
   function automatic int unsigned mdu_cnt_width(input int unsigned lat);
      return (lat > 2) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/hazard_mdu_seq.sv
// rtl/hazard_mdu_seq.sv - multi-cycle mul/div occupancy sequencer
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   mdu_start_e     mul/div op present in Execute
//   mdu_hold        Execute must stay put this cycle
//   mdu_done        op finishes (advances) at the end of this cycle
//   mdu_busy        sequencer is in the BUSY state
module hazard_mdu_seq
   import hazard_sb_pkg::*;
#(
   parameter int MDU_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic mdu_start_e,
   output logic mdu_hold,
   output logic mdu_done,
   output logic mdu_busy
);

   localparam int             CW       = mdu_cnt_width(MDU_LAT);
   localparam bit             MULTI    = (MDU_LAT > 1);
   // The start cycle is the first held cycle, so BUSY only needs LAT-2 more
   // before the final (done) cycle.
   localparam logic [CW-1:0]  CNT_INIT = CW'((MDU_LAT > 1) ? MDU_LAT - 2 : 0);

   mdu_state_e     state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= MDU_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         MDU_IDLE: begin
            if (mdu_start_e && MULTI) begin
               state_nxt = MDU_BUSY;
               cnt_nxt   = CNT_INIT;
            end
         end
         MDU_BUSY: begin
            // A start seen on the final cycle belongs to the op now leaving
            if (cnt != '0) cnt_nxt = cnt - CW'(1);
            else           state_nxt = MDU_IDLE;
         end
         default: state_nxt = MDU_IDLE;
      endcase
   end

   always_comb begin
      mdu_busy = (state == MDU_BUSY);
      mdu_hold = 1'b0;
      mdu_done = 1'b0;
      case (state)
         MDU_IDLE: begin
            mdu_hold = mdu_start_e && MULTI;
            mdu_done = mdu_start_e && !MULTI;
         end
         MDU_BUSY: begin
            mdu_hold = (cnt != '0);
            mdu_done = (cnt == '0);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hazard_sb.sv
// rtl/hazard_sb.sv - pipeline hazard scoreboard: forwarding, stalls, flushes
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   rs1_d, rs2_d, use_rs1_d, use_rs2_d Decode sources and whether they are read
//   rs1_e, rs2_e, rd_e                 Execute registers
//   pc_src_e, res_src_e_b0, mdu_start_e taken branch, load, mul/div in Execute
//   rd_m, reg_write_m, rd_w, reg_write_w  Memory/Writeback destinations
//   stall_f/d/e, flush_d/e/m           pipeline control
//   forward_a_e, forward_b_e           Execute operand select
//   mdu_busy, mdu_done                 MDU sequencer status
//   stall_count                        saturating count of stalled fetch cycles
module hazard_sb
   import hazard_sb_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic              use_rs1_d,
   input  logic              use_rs2_d,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              pc_src_e,
   input  logic              res_src_e_b0,
   input  logic              mdu_start_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic              reg_write_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_w,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_m,
   output logic              mdu_busy,
   output logic              mdu_done,
   output logic [1:0]        forward_a_e,
   output logic [1:0]        forward_b_e,
   output logic [CNT_W-1:0]  stall_count
);

   logic lw_stall;
   logic mdu_hold;

   // Memory is the younger result, so it takes priority over Writeback
   always_comb begin
      forward_a_e = FWD_RF;
      if (rs1_e != '0 && reg_write_m && rs1_e == rd_m)      forward_a_e = FWD_MEM;
      else if (rs1_e != '0 && reg_write_w && rs1_e == rd_w) forward_a_e = FWD_WB;

      forward_b_e = FWD_RF;
      if (rs2_e != '0 && reg_write_m && rs2_e == rd_m)      forward_b_e = FWD_MEM;
      else if (rs2_e != '0 && reg_write_w && rs2_e == rd_w) forward_b_e = FWD_WB;
   end

   always_comb begin
      lw_stall = res_src_e_b0 && (rd_e != '0) &&
                 ((use_rs1_d && rs1_d == rd_e) || (use_rs2_d && rs2_d == rd_e));
   end

   hazard_mdu_seq #(
      .MDU_LAT (MDU_LAT)
   ) u_mdu_seq (
      .clk         (clk),
      .rst         (rst),
      .mdu_start_e (mdu_start_e),
      .mdu_hold    (mdu_hold),
      .mdu_done    (mdu_done),
      .mdu_busy    (mdu_busy)
   );

   // While the MDU holds Execute, the load bubble is not inserted: the load
   // itself is frozen in Execute, so flushing it would lose it.
   always_comb begin
      stall_f = lw_stall || mdu_hold;
      stall_d = lw_stall || mdu_hold;
      stall_e = mdu_hold;
      flush_m = mdu_hold;
      flush_d = pc_src_e;
      flush_e = (lw_stall && !mdu_hold) || pc_src_e;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_count <= '0;
      else if (stall_f && stall_count != {CNT_W{1'b1}})
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_sb.sv
// tb/tb_hazard_sb.sv - self-checking bench for hazard_sb
module tb_hazard_sb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0, rd_e = '0, rd_m = '0, rd_w = '0;
   logic       use_rs1_d = 0, use_rs2_d = 0, pc_src_e = 0, res_src_e_b0 = 0, mdu_start_e = 0;
   logic       reg_write_m = 0, reg_write_w = 0;

   // a_: MDU_LAT=4 CNT_W=16, b_: MDU_LAT=1 CNT_W=16, c_: MDU_LAT=4 CNT_W=2
   logic a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_bz, a_dn;
   logic b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_bz, b_dn;
   logic c_sf, c_sd, c_se, c_fd, c_fe, c_fm, c_bz, c_dn;
   logic [1:0]  a_fa, a_fb, b_fa, b_fb, c_fa, c_fb;
   logic [15:0] a_sc, b_sc;
   logic [1:0]  c_sc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_sb #(.REG_AW(5), .MDU_LAT(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_src_e(pc_src_e), .res_src_e_b0(res_src_e_b0),
      .mdu_start_e(mdu_start_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
      .stall_f(a_sf), .stall_d(a_sd), .stall_e(a_se), .flush_d(a_fd), .flush_e(a_fe), .flush_m(a_fm),
      .mdu_busy(a_bz), .mdu_done(a_dn), .forward_a_e(a_fa), .forward_b_e(a_fb), .stall_count(a_sc));

   hazard_sb #(.REG_AW(5), .MDU_LAT(1), .CNT_W(16)) dut_l1 (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_src_e(pc_src_e), .res_src_e_b0(res_src_e_b0),
      .mdu_start_e(mdu_start_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
      .stall_f(b_sf), .stall_d(b_sd), .stall_e(b_se), .flush_d(b_fd), .flush_e(b_fe), .flush_m(b_fm),
      .mdu_busy(b_bz), .mdu_done(b_dn), .forward_a_e(b_fa), .forward_b_e(b_fb), .stall_count(b_sc));

   hazard_sb #(.REG_AW(5), .MDU_LAT(4), .CNT_W(2)) dut_c2 (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_src_e(pc_src_e), .res_src_e_b0(res_src_e_b0),
      .mdu_start_e(mdu_start_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w),
      .stall_f(c_sf), .stall_d(c_sd), .stall_e(c_se), .flush_d(c_fd), .flush_e(c_fe), .flush_m(c_fm),
      .mdu_busy(c_bz), .mdu_done(c_dn), .forward_a_e(c_fa), .forward_b_e(c_fb), .stall_count(c_sc));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each op is tracked as "cycles still owed" (left): a started op owes
   // LAT-1 more cycles after its start cycle; the last owed cycle is the done cycle.
   int m_left_a = 0, m_left_b = 0, m_left_c = 0;
   int m_cnt_a = 0, m_cnt_b = 0, m_cnt_c = 0;

   function automatic logic f_lw();
      return res_src_e_b0 && rd_e != 0 &&
             ((use_rs1_d && rs1_d == rd_e) || (use_rs2_d && rs2_d == rd_e));
   endfunction

   function automatic logic [1:0] f_fwd(input logic [4:0] rs);
      if (rs != 0 && reg_write_m && rs == rd_m) return 2'b10;
      if (rs != 0 && reg_write_w && rs == rd_w) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic f_hold(input int lat, input int left);
      return (left == 0) ? (mdu_start_e && lat > 1) : (left > 1);
   endfunction

   function automatic logic f_done(input int lat, input int left);
      return (left == 0) ? (mdu_start_e && lat == 1) : (left == 1);
   endfunction

   function automatic int nxt_left(input int lat, input int left);
      if (left == 0) return (mdu_start_e && lat > 1) ? lat - 1 : 0;
      return left - 1;
   endfunction

   function automatic int nxt_cnt(input int c, input int w, input logic s);
      if (s && c < (1 << w) - 1) return c + 1;
      return c;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_left_a <= 0; m_left_b <= 0; m_left_c <= 0;
         m_cnt_a  <= 0; m_cnt_b  <= 0; m_cnt_c  <= 0;
      end else begin
         m_left_a <= nxt_left(4, m_left_a);
         m_left_b <= nxt_left(1, m_left_b);
         m_left_c <= nxt_left(4, m_left_c);
         m_cnt_a  <= nxt_cnt(m_cnt_a, 16, f_lw() || f_hold(4, m_left_a));
         m_cnt_b  <= nxt_cnt(m_cnt_b, 16, f_lw() || f_hold(1, m_left_b));
         m_cnt_c  <= nxt_cnt(m_cnt_c, 2,  f_lw() || f_hold(4, m_left_c));
      end
   end

   task automatic cmp_inst(input string n, input int lat, input int left, input int cnt,
                           input logic sf, input logic sd, input logic se, input logic fd,
                           input logic fe, input logic fm, input logic bz, input logic dn,
                           input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] sc);
      logic lw, hold;
      lw   = f_lw();
      hold = f_hold(lat, left);
      chk({n, ".stall_f"},     sf, lw | hold);
      chk({n, ".stall_d"},     sd, lw | hold);
      chk({n, ".stall_e"},     se, hold);
      chk({n, ".flush_m"},     fm, hold);
      chk({n, ".flush_d"},     fd, pc_src_e);
      chk({n, ".flush_e"},     fe, (lw && !hold) || pc_src_e);
      chk({n, ".mdu_busy"},    bz, left > 0);
      chk({n, ".mdu_done"},    dn, f_done(lat, left));
      chk({n, ".forward_a_e"}, fa, f_fwd(rs1_e));
      chk({n, ".forward_b_e"}, fb, f_fwd(rs2_e));
      chk({n, ".stall_count"}, sc, cnt);
   endtask

   always @(negedge clk) begin
      assert (!(pc_src_e && mdu_start_e)) else $error("pc_src_e and mdu_start_e both high");
      assert (!(res_src_e_b0 && mdu_start_e)) else $error("res_src_e_b0 and mdu_start_e both high");
      cmp_inst("lat4", 4, m_left_a, m_cnt_a, a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_bz, a_dn, a_fa, a_fb, a_sc);
      cmp_inst("lat1", 1, m_left_b, m_cnt_b, b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_bz, b_dn, b_fa, b_fb, b_sc);
      cmp_inst("cnt2", 4, m_left_c, m_cnt_c, c_sf, c_sd, c_se, c_fd, c_fe, c_fm, c_bz, c_dn, c_fa, c_fb, {14'd0, c_sc});
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
      use_rs1_d = 0; use_rs2_d = 0; pc_src_e = 0; res_src_e_b0 = 0; mdu_start_e = 0;
      reg_write_m = 0; reg_write_w = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      tick(); tick();
      settle();
      chk("reset.stall_count", a_sc, 0);
      chk("reset.mdu_busy", a_bz, 0);
      chk("reset.stall_f", a_sf, 0);
      tick();
      rst = 1'b1;
      tick();

      // Forwarding: Memory beats Writeback, x0 never forwards
      rs1_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
      settle();
      chk("fwd.mem_priority", a_fa, 2'b10);
      tick();
      rs1_e = 0;
      settle();
      chk("fwd.x0", a_fa, 2'b00);
      tick();
      rs2_e = 5; reg_write_m = 0;
      settle();
      chk("fwd.wb", a_fb, 2'b01);
      tick();
      idle_inputs();

      // Load-use
      res_src_e_b0 = 1; rd_e = 7; rs2_d = 7; use_rs2_d = 1;
      settle();
      chk("lw.stall_f", a_sf, 1);
      chk("lw.flush_e", a_fe, 1);
      chk("lw.stall_e", a_se, 0);
      tick();
      use_rs2_d = 0;
      settle();
      chk("lw.unused_src", a_sf, 0);
      chk("lw.count1", a_sc, 1);
      tick();
      use_rs2_d = 1; rd_e = 0;
      settle();
      chk("lw.rd_x0", a_sf, 0);
      tick();
      idle_inputs();

      // MDU op held 4 cycles
      mdu_start_e = 1;
      settle();
      chk("mdu.t0_stall_e", a_se, 1);
      chk("mdu.t0_flush_m", a_fm, 1);
      chk("mdu.lat1_done", b_dn, 1);
      chk("mdu.lat1_stall", b_sf, 0);
      tick(); tick(); tick();
      settle();
      chk("mdu.t3_done", a_dn, 1);
      chk("mdu.t3_stall_e", a_se, 0);
      chk("mdu.t3_count", a_sc, 4);
      chk("mdu.lat1_busy", b_bz, 0);
      chk("mdu.lat1_count", b_sc, 1);
      tick();
      idle_inputs();
      settle();
      chk("mdu.after_busy", a_bz, 0);
      tick();

      // Taken branch, then one more load-use stall to saturate the 2-bit counter
      pc_src_e = 1;
      settle();
      chk("br.flush_d", a_fd, 1);
      chk("br.flush_e", a_fe, 1);
      chk("br.stall_f", a_sf, 0);
      tick();
      idle_inputs();
      res_src_e_b0 = 1; rd_e = 3; rs1_d = 3; use_rs1_d = 1;
      tick();
      idle_inputs();
      settle();
      chk("sat.count16", a_sc, 5);
      chk("sat.count2", c_sc, 2'd3);
      tick();

      // Reset in the middle of an op
      mdu_start_e = 1;
      settle();
      chk("rst.t0_stall_e", a_se, 1);
      tick();
      mdu_start_e = 0;
      #1 rst = 1'b0;
      settle();
      chk("rst.mdu_busy", a_bz, 0);
      chk("rst.stall_e", a_se, 0);
      chk("rst.count", a_sc, 0);
      chk("rst.count2", c_sc, 0);
      #1 rst = 1'b1;
      tick();
      settle();
      chk("rst.abandoned", a_bz, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_sb.md
HAZARD_SB -- requirements
Module: hazard_sb

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter MDU_LAT, default 4, range 1..16, meaning cycles a mul/div op occupies Execute.
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports rs1_d, rs2_d  in  REG_AW  Decode source registers; use_rs1_d, use_rs2_d  in  1  source actually read.
REQ-007 SHALL have ports rs1_e, rs2_e, rd_e  in  REG_AW  Execute registers; pc_src_e  in  1  taken branch/jump; res_src_e_b0  in  1  load in Execute; mdu_start_e  in  1  mul/div op in Execute.
REQ-008 SHALL have ports rd_m  in  REG_AW; reg_write_m  in  1; rd_w  in  REG_AW; reg_write_w  in  1.
REQ-009 SHALL have outputs stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, mdu_done  each 1.
REQ-010 SHALL have outputs forward_a_e, forward_b_e  2  operand select: 00 register file, 01 Writeback, 10 Memory.
REQ-011 SHALL have output stall_count  CNT_W  saturating count of stalled fetch cycles.

Function
REQ-012 Forwarding SHALL be combinational: select 10 when rsX_e==rd_m, reg_write_m, rsX_e!=0; else 01 when rsX_e==rd_w, reg_write_w, rsX_e!=0; else 00; Memory wins over Writeback.
REQ-013 Load-use stall SHALL be res_src_e_b0 & rd_e!=0 & ((use_rs1_d & rs1_d==rd_e) | (use_rs2_d & rs2_d==rd_e)).
REQ-014 MDU FSM SHALL have states IDLE and BUSY with down-counter cnt of width ceil(log2(MDU_LAT)), minimum 1.
REQ-015 IDLE & mdu_start_e & MDU_LAT>1 SHALL go to BUSY with cnt<=MDU_LAT-2; MDU_LAT==1 SHALL remain IDLE, no stall.
REQ-016 BUSY & cnt!=0 SHALL decrement cnt; BUSY & cnt==0 SHALL return to IDLE and ignore mdu_start_e that cycle.
REQ-017 mdu_hold = (IDLE & mdu_start_e & MDU_LAT>1) | (BUSY & cnt!=0); an op starting in cycle T SHALL be held exactly MDU_LAT-1 cycles and advance at end of T+MDU_LAT-1.
REQ-018 mdu_done SHALL be 1 in cycle T+MDU_LAT-1 (in cycle T when MDU_LAT==1); mdu_busy SHALL equal state==BUSY.
REQ-019 stall_f = stall_d = lw_stall | mdu_hold; stall_e = mdu_hold; flush_m = mdu_hold.
REQ-020 flush_d SHALL equal pc_src_e; flush_e SHALL equal (lw_stall & !mdu_hold) | pc_src_e.
REQ-021 pc_src_e and mdu_start_e SHALL be mutually exclusive; res_src_e_b0 and mdu_start_e SHALL be mutually exclusive; the bench SHALL assert this.
REQ-022 The MDU SHALL latch operands in cycle T; forwarding during hold is don't-care to the datapath but SHALL still follow REQ-012.
REQ-023 stall_count SHALL increment by 1 each cycle stall_f==1 and hold at all-ones.

Reset
REQ-024 rst low SHALL force IDLE, cnt=0, stall_count=0 immediately, including mid-BUSY; the in-flight op is abandoned.
REQ-025 During reset all combinational outputs SHALL follow their equations with state IDLE.

Structure
REQ-026 Forward-select encodings (FWD_RF, FWD_WB, FWD_MEM) and FSM state encodings SHALL live in the shared pipeline package.
REQ-027 The MDU sequencer (FSM, cnt, mdu_hold, mdu_done) SHALL be sub-module hazard_mdu_seq; forwarding and load-use logic stay in hazard_sb.

Verification
REQ-028 rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> forward_a_e=10; rs1_e=0 with same -> 00.
REQ-029 res_src_e_b0=1, rd_e=7, rs2_d=7, use_rs2_d=1 -> stall_f=stall_d=flush_e=1 one cycle; use_rs2_d=0 or rd_e=0 -> no stall.
REQ-030 MDU_LAT=4, mdu_start_e held 4 cycles from T -> stall_e=flush_m=1 in T..T+2, mdu_done=1 at T+3, stall_count +3.
REQ-031 MDU_LAT=1, mdu_start_e=1 -> no stall, mdu_done=1 same cycle, mdu_busy stays 0.
REQ-032 rst pulsed low at T+1 of a 4-cycle op -> mdu_busy=0, stall_e=0, stall_count=0 before next clk edge.
REQ-033 pc_src_e=1 -> flush_d=flush_e=1, stall_f=0; CNT_W=2 with 5 stall cycles -> stall_count=3.
